// File: rtl/tap_pkg.sv
// Shared IEEE 1149.1 TAP definitions: state codes and instruction opcodes.
package tap_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 4;

  // Standard 1149.1 state encoding
  typedef enum logic [STATE_W-1:0] {
    ST_EX2DR   = 4'h0,
    ST_EX1DR   = 4'h1,
    ST_SHDR    = 4'h2,
    ST_PAUSEDR = 4'h3,
    ST_SELIR   = 4'h4,
    ST_UPDDR   = 4'h5,
    ST_CAPDR   = 4'h6,
    ST_SELDR   = 4'h7,
    ST_EX2IR   = 4'h8,
    ST_EX1IR   = 4'h9,
    ST_SHIR    = 4'hA,
    ST_PAUSEIR = 4'hB,
    ST_RTI     = 4'hC,
    ST_UPDIR   = 4'hD,
    ST_CAPIR   = 4'hE,
    ST_TLR     = 4'hF
  } tap_state_e;

  // Instruction opcodes
  localparam logic [OPCODE_W-1:0] OP_BYPASS   = 4'hF;
  localparam logic [OPCODE_W-1:0] OP_SAMPLE   = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_EXTEST   = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_INTEST   = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_RUNBIST  = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_CLAMP    = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_IDCODE   = 4'h7;
  localparam logic [OPCODE_W-1:0] OP_USERCODE = 4'h8;
  localparam logic [OPCODE_W-1:0] OP_HIGHZ    = 4'h9;

endpackage

// File: rtl/tap_fsm.sv
// 16-state TAP state machine driven by TMS on posedge TCK.
module tap_fsm
  import tap_pkg::*;
(
  input  logic               TCK,
  input  logic               TRST,
  input  logic               TMS,
  output logic [STATE_W-1:0] STATE
);

  tap_state_e state_q;
  tap_state_e state_d;

  // State register; TRST forces Test-Logic-Reset immediately
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      state_q <= ST_TLR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, TMS=0 / TMS=1 branches
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TLR:     state_d = TMS ? ST_TLR     : ST_RTI;
      ST_RTI:     state_d = TMS ? ST_SELDR   : ST_RTI;
      ST_SELDR:   state_d = TMS ? ST_SELIR   : ST_CAPDR;
      ST_CAPDR:   state_d = TMS ? ST_EX1DR   : ST_SHDR;
      ST_SHDR:    state_d = TMS ? ST_EX1DR   : ST_SHDR;
      ST_EX1DR:   state_d = TMS ? ST_UPDDR   : ST_PAUSEDR;
      ST_PAUSEDR: state_d = TMS ? ST_EX2DR   : ST_PAUSEDR;
      ST_EX2DR:   state_d = TMS ? ST_UPDDR   : ST_SHDR;
      ST_UPDDR:   state_d = TMS ? ST_SELDR   : ST_RTI;
      ST_SELIR:   state_d = TMS ? ST_TLR     : ST_CAPIR;
      ST_CAPIR:   state_d = TMS ? ST_EX1IR   : ST_SHIR;
      ST_SHIR:    state_d = TMS ? ST_EX1IR   : ST_SHIR;
      ST_EX1IR:   state_d = TMS ? ST_UPDIR   : ST_PAUSEIR;
      ST_PAUSEIR: state_d = TMS ? ST_EX2IR   : ST_PAUSEIR;
      ST_EX2IR:   state_d = TMS ? ST_UPDIR   : ST_SHIR;
      ST_UPDIR:   state_d = TMS ? ST_SELDR   : ST_RTI;
      default:    state_d = ST_TLR;
    endcase
  end

  assign STATE = state_q;

endmodule

// File: rtl/tap_controller.sv
// TAP controller: FSM, instruction register, BYPASS register and TDO mux.
module tap_controller
  import tap_pkg::*;
#(
  parameter int unsigned          IR_WIDTH   = 4,
  parameter logic [IR_WIDTH-1:0]  IR_RESET   = IR_WIDTH'(4'h7),
  parameter logic [IR_WIDTH-1:0]  IR_CAPTURE = IR_WIDTH'(4'b0001)
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  input  logic                BSR_TDO,
  input  logic                ID_TDO,
  input  logic                USER_TDO,
  output logic                TLR,
  output logic                CAPTURE_DR,
  output logic                SHIFT_DR,
  output logic                UPDATE_DR,
  output logic [IR_WIDTH-1:0] LATCH_IR,
  output logic                ENABLE,
  output logic                TDO,
  output logic [STATE_W-1:0]  STATE
);

  logic [STATE_W-1:0]  state;
  logic                in_capir;
  logic                in_shir;
  logic                in_updir;

  logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
  logic                bypass_q, bypass_d;
  logic                ir_tdo_q;
  logic                byp_tdo_q;
  logic [IR_WIDTH-1:0] latch_ir_q, latch_ir_d;
  logic                dr_tdo_c;

  tap_fsm u_fsm (
    .TCK   (TCK),
    .TRST  (TRST),
    .TMS   (TMS),
    .STATE (state)
  );

  // State decodes
  assign TLR        = (state == ST_TLR);
  assign CAPTURE_DR = (state == ST_CAPDR);
  assign SHIFT_DR   = (state == ST_SHDR);
  assign UPDATE_DR  = (state == ST_UPDDR);
  assign in_capir   = (state == ST_CAPIR);
  assign in_shir    = (state == ST_SHIR);
  assign in_updir   = (state == ST_UPDIR);
  assign ENABLE     = SHIFT_DR | in_shir;
  assign STATE      = state;
  assign LATCH_IR   = latch_ir_q;

  // IR shift register and BYPASS next values; hold outside capture/shift
  always_comb begin
    ir_sr_d  = ir_sr_q;
    bypass_d = bypass_q;
    if (in_capir) begin
      ir_sr_d = IR_CAPTURE;
    end else if (in_shir) begin
      ir_sr_d = {TDI, ir_sr_q[IR_WIDTH-1:1]};
    end
    if (CAPTURE_DR) begin
      bypass_d = 1'b0;
    end else if (SHIFT_DR) begin
      bypass_d = TDI;
    end
  end

  // Posedge shift registers
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      ir_sr_q  <= IR_CAPTURE;
      bypass_q <= 1'b0;
    end else begin
      ir_sr_q  <= ir_sr_d;
      bypass_q <= bypass_d;
    end
  end

  // Active instruction: reset value in TLR, shifted value in UpdIR
  always_comb begin
    latch_ir_d = latch_ir_q;
    if (TLR) begin
      latch_ir_d = IR_RESET;
    end else if (in_updir) begin
      latch_ir_d = ir_sr_q;
    end
  end

  // Negedge stage: serial outputs and the instruction latch
  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      ir_tdo_q   <= 1'b0;
      byp_tdo_q  <= 1'b0;
      latch_ir_q <= IR_RESET;
    end else begin
      ir_tdo_q   <= ir_sr_q[0];
      byp_tdo_q  <= bypass_q;
      latch_ir_q <= latch_ir_d;
    end
  end

  // DR source select from the active instruction; unknown opcodes use BYPASS
  always_comb begin
    dr_tdo_c = byp_tdo_q;
    if (latch_ir_q == IR_WIDTH'(OP_IDCODE)) begin
      dr_tdo_c = ID_TDO;
    end else if (latch_ir_q == IR_WIDTH'(OP_USERCODE)) begin
      dr_tdo_c = USER_TDO;
    end else if ((latch_ir_q == IR_WIDTH'(OP_SAMPLE)) ||
                 (latch_ir_q == IR_WIDTH'(OP_EXTEST)) ||
                 (latch_ir_q == IR_WIDTH'(OP_INTEST))) begin
      dr_tdo_c = BSR_TDO;
    end
  end

  // Chip TDO, zero whenever not shifting
  always_comb begin
    TDO = 1'b0;
    if (in_shir) begin
      TDO = ir_tdo_q;
    end else if (SHIFT_DR) begin
      TDO = dr_tdo_c;
    end
  end

endmodule

// File: tb/tb_tap_controller.sv
// Self-checking bench for tap_controller.
module tb_tap_controller;

  logic       TCK;
  logic       TRST;
  logic       TMS;
  logic       TDI;
  logic       BSR_TDO;
  logic       ID_TDO;
  logic       USER_TDO;
  logic       TLR;
  logic       CAPTURE_DR;
  logic       SHIFT_DR;
  logic       UPDATE_DR;
  logic [3:0] LATCH_IR;
  logic       ENABLE;
  logic       TDO;
  logic [3:0] STATE;

  tap_controller dut (
    .TCK        (TCK),
    .TRST       (TRST),
    .TMS        (TMS),
    .TDI        (TDI),
    .BSR_TDO    (BSR_TDO),
    .ID_TDO     (ID_TDO),
    .USER_TDO   (USER_TDO),
    .TLR        (TLR),
    .CAPTURE_DR (CAPTURE_DR),
    .SHIFT_DR   (SHIFT_DR),
    .UPDATE_DR  (UPDATE_DR),
    .LATCH_IR   (LATCH_IR),
    .ENABLE     (ENABLE),
    .TDO        (TDO),
    .STATE      (STATE)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  int n_pass;
  int n_total;

  // Reference model: state transition table and register contents as integers
  int nxt0 [16];
  int nxt1 [16];
  int m_st, m_ir, m_latch, m_byp, m_irtdo, m_byptdo;

  typedef struct {
    logic       tms;
    logic       tdi;
    logic [3:0] st;
    logic       tdo;
    logic [3:0] ir;
  } vec_t;

  vec_t  vecs [11];
  string paths [16];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void build_table();
    // state: next for TMS=0, next for TMS=1
    nxt0[15] = 12; nxt1[15] = 15;
    nxt0[12] = 12; nxt1[12] = 7;
    nxt0[7]  = 6;  nxt1[7]  = 4;
    nxt0[6]  = 2;  nxt1[6]  = 1;
    nxt0[2]  = 2;  nxt1[2]  = 1;
    nxt0[1]  = 3;  nxt1[1]  = 5;
    nxt0[3]  = 3;  nxt1[3]  = 0;
    nxt0[0]  = 2;  nxt1[0]  = 5;
    nxt0[5]  = 12; nxt1[5]  = 7;
    nxt0[4]  = 14; nxt1[4]  = 15;
    nxt0[14] = 10; nxt1[14] = 9;
    nxt0[10] = 10; nxt1[10] = 9;
    nxt0[9]  = 11; nxt1[9]  = 13;
    nxt0[11] = 11; nxt1[11] = 8;
    nxt0[8]  = 10; nxt1[8]  = 13;
    nxt0[13] = 12; nxt1[13] = 7;
  endfunction

  function automatic void model_reset();
    m_st = 15; m_ir = 1; m_latch = 7; m_byp = 0; m_irtdo = 0; m_byptdo = 0;
  endfunction

  // One TCK: posedge effects from the current state, then negedge effects
  function automatic void model_step(input logic tms, input logic tdi);
    if (m_st == 14) m_ir = 1;
    else if (m_st == 10) m_ir = (m_ir >> 1) | (int'(tdi) << 3);
    if (m_st == 6) m_byp = 0;
    else if (m_st == 2) m_byp = int'(tdi);
    m_st = tms ? nxt1[m_st] : nxt0[m_st];
    m_irtdo  = m_ir & 1;
    m_byptdo = m_byp;
    if (m_st == 13) m_latch = m_ir;
    if (m_st == 15) m_latch = 7;
  endfunction

  function automatic int exp_tdo();
    if (m_st == 10) return m_irtdo;
    if (m_st != 2) return 0;
    case (m_latch)
      7:       return int'(ID_TDO);
      8:       return int'(USER_TDO);
      1, 2, 3: return int'(BSR_TDO);
      default: return m_byptdo;
    endcase
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".state"},  int'(STATE),      m_st);
    check({tag, ".tlr"},    int'(TLR),        int'(m_st == 15));
    check({tag, ".cap"},    int'(CAPTURE_DR), int'(m_st == 6));
    check({tag, ".shdr"},   int'(SHIFT_DR),   int'(m_st == 2));
    check({tag, ".upd"},    int'(UPDATE_DR),  int'(m_st == 5));
    check({tag, ".enable"}, int'(ENABLE),     int'(m_st == 2 || m_st == 10));
    check({tag, ".latch"},  int'(LATCH_IR),   m_latch);
    check({tag, ".tdo"},    int'(TDO),        exp_tdo());
  endtask

  // Drive TMS/TDI, advance one TCK, return 2 time units after the negedge
  task automatic tick(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    model_step(tms, tdi);
    @(posedge TCK);
    @(negedge TCK);
    #2;
  endtask

  task automatic go_tlr();
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
  endtask

  task automatic load_ir(input int v);
    go_tlr();
    tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b1, 1'b0);
    tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(logic'(i == 3), logic'((v >> i) & 1));
    tick(1'b1, 1'b0); tick(1'b0, 1'b0);
  endtask

  // DR scan from RTI; collects TDO per shift cycle and strobe counts
  task automatic dr_scan(input int n, input int tdi_bits, input bit rand_dr,
                         output int tdo_bits, output int id_bits,
                         output int cap_cnt, output int sh_cnt, output int upd_cnt);
    tdo_bits = 0; id_bits = 0; cap_cnt = 0; sh_cnt = 0; upd_cnt = 0;
    tick(1'b1, 1'b0);
    cap_cnt += int'(CAPTURE_DR);
    tick(1'b0, 1'b0);
    cap_cnt += int'(CAPTURE_DR);
    tick(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (rand_dr) begin
        BSR_TDO  = 1'($urandom);
        ID_TDO   = 1'($urandom);
        USER_TDO = 1'($urandom);
        #1;
      end
      cap_cnt  += int'(CAPTURE_DR);
      sh_cnt   += int'(SHIFT_DR);
      upd_cnt  += int'(UPDATE_DR);
      tdo_bits |= int'(TDO) << i;
      id_bits  |= int'(ID_TDO) << i;
      tick(logic'(i == n - 1), logic'((tdi_bits >> i) & 1));
    end
    sh_cnt  += int'(SHIFT_DR);
    tick(1'b1, 1'b0);
    upd_cnt += int'(UPDATE_DR);
    tick(1'b0, 1'b0);
    upd_cnt += int'(UPDATE_DR);
    sh_cnt  += int'(SHIFT_DR);
  endtask

  initial begin
    int tdo_b, id_b, cap_c, sh_c, upd_c;
    n_pass = 0; n_total = 0;
    build_table();
    TMS = 1'b1; TDI = 1'b0; BSR_TDO = 1'b0; ID_TDO = 1'b0; USER_TDO = 1'b0;

    vecs[0]  = '{1'b0, 1'b0, 4'hC, 1'b0, 4'h7};
    vecs[1]  = '{1'b1, 1'b0, 4'h7, 1'b0, 4'h7};
    vecs[2]  = '{1'b1, 1'b0, 4'h4, 1'b0, 4'h7};
    vecs[3]  = '{1'b0, 1'b0, 4'hE, 1'b0, 4'h7};
    vecs[4]  = '{1'b0, 1'b0, 4'hA, 1'b1, 4'h7};
    vecs[5]  = '{1'b0, 1'b0, 4'hA, 1'b0, 4'h7};
    vecs[6]  = '{1'b0, 1'b1, 4'hA, 1'b0, 4'h7};
    vecs[7]  = '{1'b0, 1'b0, 4'hA, 1'b0, 4'h7};
    vecs[8]  = '{1'b1, 1'b0, 4'h9, 1'b0, 4'h7};
    vecs[9]  = '{1'b1, 1'b0, 4'hD, 1'b0, 4'h2};
    vecs[10] = '{1'b0, 1'b0, 4'hC, 1'b0, 4'h2};

    paths[15] = "";        paths[12] = "0";       paths[7]  = "01";
    paths[6]  = "010";     paths[2]  = "0100";    paths[1]  = "0101";
    paths[3]  = "01010";   paths[0]  = "010101";  paths[5]  = "01011";
    paths[4]  = "011";     paths[14] = "0110";    paths[10] = "01100";
    paths[9]  = "01101";   paths[11] = "011010";  paths[8]  = "0110101";
    paths[13] = "011011";

    // Power-on reset
    TRST = 1'b0;
    @(negedge TCK);
    #2;
    TRST = 1'b1;
    model_reset();
    check("reset.state", int'(STATE), 15);
    check("reset.tlr", int'(TLR), 1);
    check("reset.latch", int'(LATCH_IR), 7);
    check("reset.tdo", int'(TDO), 0);
    check_all("reset");

    // IR scan of opcode 2 from the vector table
    for (int i = 0; i < 11; i++) begin
      tick(vecs[i].tms, vecs[i].tdi);
      check($sformatf("irscan[%0d].state", i), int'(STATE), int'(vecs[i].st));
      check($sformatf("irscan[%0d].tdo", i), int'(TDO), int'(vecs[i].tdo));
      check($sformatf("irscan[%0d].latch", i), int'(LATCH_IR), int'(vecs[i].ir));
    end

    // Asynchronous reset in the middle of a DR shift, TCK high
    BSR_TDO = 1'b1;
    tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    check("midscan.pre_state", int'(STATE), 2);
    check("midscan.pre_tdo", int'(TDO), 1);
    @(posedge TCK);
    #2;
    TRST = 1'b0;
    #1;
    check("async.state", int'(STATE), 15);
    check("async.tlr", int'(TLR), 1);
    check("async.latch", int'(LATCH_IR), 7);
    check("async.tdo", int'(TDO), 0);
    check("async.enable", int'(ENABLE), 0);
    check("async.shdr", int'(SHIFT_DR), 0);
    @(negedge TCK);
    #2;
    TRST = 1'b1;
    model_reset();
    BSR_TDO = 1'b0;

    // Five TMS=1 cycles reach TLR from every state
    for (int s = 0; s < 16; s++) begin
      go_tlr();
      for (int k = 0; k < paths[s].len(); k++) tick(logic'(paths[s][k] == "1"), 1'b0);
      check($sformatf("walk[%0d].at", s), int'(STATE), s);
      go_tlr();
      check($sformatf("walk[%0d].tlr", s), int'(STATE), 15);
      tick(1'b0, 1'b0);
      check($sformatf("walk[%0d].rti", s), int'(STATE), 12);
    end

    // IDCODE DR scan of 8 bits after reset
    TRST = 1'b0;
    #1;
    TRST = 1'b1;
    model_reset();
    tick(1'b0, 1'b0);
    dr_scan(8, 8'hA5, 1'b1, tdo_b, id_b, cap_c, sh_c, upd_c);
    check("idscan.cap_cycles", cap_c, 1);
    check("idscan.shift_cycles", sh_c, 8);
    check("idscan.tdo_vs_id", tdo_b, id_b);
    check("idscan.upd_cycles", upd_c, 1);

    // BYPASS: capture 0 then TDI delayed one cycle
    load_ir(15);
    check("byp.latch", int'(LATCH_IR), 15);
    dr_scan(4, 13, 1'b0, tdo_b, id_b, cap_c, sh_c, upd_c);
    check("byp.tdo", tdo_b, 10);

    // Undefined opcode falls back to BYPASS and ignores the DR sources
    load_ir(12);
    check("undef.latch", int'(LATCH_IR), 12);
    BSR_TDO = 1'b1; ID_TDO = 1'b1; USER_TDO = 1'b1;
    dr_scan(4, 6, 1'b0, tdo_b, id_b, cap_c, sh_c, upd_c);
    check("undef.tdo", tdo_b, 12);
    check("undef.upd_cycles", upd_c, 1);
    check("undef.cap_cycles", cap_c, 1);

    // Random TMS/TDI/DR traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      BSR_TDO  = 1'($urandom);
      ID_TDO   = 1'($urandom);
      USER_TDO = 1'($urandom);
      tick(logic'($urandom_range(0, 9) < 4), 1'($urandom));
      check_all($sformatf("rand[%0d]", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
